uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_arb_pkg.sv | 17 +
 rtl/uart_rr_pick.sv | 30 +++
 rtl/uart_tx_arb.sv | 115 +++++++++++
 tb/tb_uart_tx_arb.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// The SEND_ID state exists only when UART_ARB_ID_EN is defined.
package uart_arb_pkg;

    localparam int         BYTE_W    = 8;
    localparam logic [4:0] ID_PREFIX = 5'b10100;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
`ifdef UART_ARB_ID_EN
        SEND_ID = 2'd2,
`endif
        SEND    = 2'd3
    } state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// scanning upward and wrapping from NREQ-1 back to 0.
module uart_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            any,
    output logic [IDW-1:0]  winner
);

    int idx;

    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = (int'(ptr) + off) % NREQ;
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter granting whole packets from NREQ requesters to one UART.
// Define UART_ARB_ID_EN to prefix each packet with an ID byte {ID_PREFIX, id}.
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [BYTE_W*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]        req_last,
    output logic [NREQ-1:0]        req_ready,
    output logic [BYTE_W-1:0]      uart_data,
    output logic                   uart_valid,
    input  logic                   uart_ready,
    output logic [IDW-1:0]         grant_id,
    output logic                   busy
);

    state_t             state, state_nxt;
    logic [IDW-1:0]     ptr, ptr_nxt;
    logic [IDW-1:0]     grant_nxt;
    logic               pick_any;
    logic [IDW-1:0]     pick_winner;
    logic               own_valid;
    logic               own_last;
    logic [BYTE_W-1:0]  own_data;
    logic               xfer;
    logic [IDW-1:0]     ptr_after;
`ifdef UART_ARB_ID_EN
    logic [2:0]         id3;

    assign id3 = 3'(grant_id);
`endif

    uart_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req    (req_valid),
        .ptr    (ptr),
        .any    (pick_any),
        .winner (pick_winner)
    );

    assign own_valid = req_valid[grant_id];
    assign own_last  = req_last[grant_id];
    assign own_data  = req_data[int'(grant_id)*BYTE_W +: BYTE_W];
    assign xfer      = own_valid && uart_ready;
    assign ptr_after = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
    assign busy      = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            grant_id <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            grant_id <= grant_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        grant_nxt  = grant_id;
        uart_valid = 1'b0;
        uart_data  = '0;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    grant_nxt = pick_winner;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
`ifdef UART_ARB_ID_EN
                state_nxt = SEND_ID;
`else
                state_nxt = SEND;
`endif
            end
`ifdef UART_ARB_ID_EN
            SEND_ID: begin
                uart_valid = 1'b1;
                uart_data  = {ID_PREFIX, id3};
                if (uart_ready) begin
                    state_nxt = SEND;
                end
            end
`endif
            SEND: begin
                // Owner keeps the grant through valid gaps until its last byte moves.
                uart_valid          = own_valid;
                uart_data           = own_data;
                req_ready[grant_id] = uart_ready;
                if (xfer && own_last) begin
                    state_nxt = IDLE;
                    ptr_nxt   = ptr_after;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb (NREQ=4); expects ID bytes when UART_ARB_ID_EN is defined.
module tb_uart_tx_arb;

    localparam int NREQ = 4;
`ifdef UART_ARB_ID_EN
    localparam bit ID_EN = 1'b1;
`else
    localparam bit ID_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      req_valid;
    logic [31:0]     req_data;
    logic [3:0]      req_last;
    logic [3:0]      req_ready;
    logic [7:0]      uart_data;
    logic            uart_valid;
    logic            uart_ready;
    logic [1:0]      grant_id;
    logic            busy;

    typedef struct {
        logic [1:0] gid;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t got;
    int   vectors     = 0;
    int   miscompares = 0;

    uart_tx_arb #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .uart_data  (uart_data),
        .uart_valid (uart_valid),
        .uart_ready (uart_ready),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Scoreboard pop on every UART transfer; also guard the one-hot req_ready rule.
    always @(negedge clk) begin
        if (rst_n && busy) begin
            vectors++;
            if ((req_ready & ~(4'b0001 << grant_id)) != 4'b0000) begin
                miscompares++;
                $display("FAIL ready_onehot: req_ready=%b grant_id=%0d, required only bit grant_id", req_ready, grant_id);
            end
        end
        if (rst_n && uart_valid && uart_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL uart_xfer: unexpected byte %h from grant %0d, required no transfer", uart_data, grant_id);
            end else begin
                got = sb.pop_front();
                if (uart_data !== got.data || grant_id !== got.gid) begin
                    miscompares++;
                    $display("FAIL uart_xfer: got grant %0d byte %h, required grant %0d byte %h",
                             grant_id, uart_data, got.gid, got.data);
                end
            end
        end
    end

    task automatic push_byte(input logic [1:0] gid, input logic [7:0] d, input bit first);
        exp_t e;
        if (first && ID_EN) begin
            e.gid  = gid;
            e.data = {5'b10100, 1'b0, gid};
            sb.push_back(e);
        end
        e.gid  = gid;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [7:0] d, input logic last);
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = d;
        req_last[i]        = last;
    endtask

    task automatic drop(input int i);
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
    endtask

    // Returns just after the clock edge on which requester i's byte was accepted.
    task automatic wait_accept(input int i, input bit now);
        bit ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (!(now && k == 0)) @(negedge clk);
            if (req_valid[i] && req_ready[i]) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL accept_%0d: req_ready=%b after 60 cycles, required bit %0d high", i, req_ready, i);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        uart_ready = 1'b1;
        req_valid  = '1;
        req_data   = 32'hFFFF_FFFF;
        req_last   = '1;
        repeat (2) @(negedge clk);
        vectors += 5;
        if (uart_valid !== 1'b0) begin miscompares++; $display("FAIL rst_uart_valid: got %b, required 0", uart_valid); end
        if (req_ready !== 4'b0)  begin miscompares++; $display("FAIL rst_req_ready: got %b, required 0000", req_ready); end
        if (uart_data !== 8'h00) begin miscompares++; $display("FAIL rst_uart_data: got %h, required 00", uart_data); end
        if (grant_id !== 2'd0)   begin miscompares++; $display("FAIL rst_grant_id: got %0d, required 0", grant_id); end
        if (busy !== 1'b0)       begin miscompares++; $display("FAIL rst_busy: got %b, required 0", busy); end
        @(posedge clk);
        #1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        rst_n     = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b, required 0", busy); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_two_packets();
        push_byte(2'd0, 8'hA0, 1'b1);
        push_byte(2'd0, 8'hA1, 1'b0);
        push_byte(2'd2, 8'hC0, 1'b1);
        push_byte(2'd2, 8'hC1, 1'b0);
        set_req(0, 8'hA0, 1'b0);
        set_req(2, 8'hC0, 1'b0);
        wait_accept(0, 1'b0);
        set_req(0, 8'hA1, 1'b1);
        wait_accept(0, 1'b0);
        drop(0);
        wait_accept(2, 1'b0);
        set_req(2, 8'hC1, 1'b1);
        wait_accept(2, 1'b0);
        drop(2);
    endtask

    // Pointer is 3 after the previous packet from requester 2, so order is 3,0,1,2.
    task automatic test_rotation();
        for (int i = 0; i < 4; i++) push_byte(2'((i + 3) % 4), 8'h10 + 8'((i + 3) % 4), 1'b1);
        for (int i = 0; i < 4; i++) set_req(i, 8'h10 + 8'(i), 1'b1);
        for (int i = 0; i < 4; i++) begin
            wait_accept((i + 3) % 4, 1'b0);
            drop((i + 3) % 4);
        end
    endtask

    task automatic test_latency();
        push_byte(2'd0, 8'h11, 1'b1);
        set_req(0, 8'h11, 1'b1);
        @(negedge clk);
        vectors += 2;
        if (uart_valid !== 1'b0) begin miscompares++; $display("FAIL lat_c0_valid: got %b, required 0", uart_valid); end
        if (busy !== 1'b0)       begin miscompares++; $display("FAIL lat_c0_busy: got %b, required 0", busy); end
        @(negedge clk);
        vectors += 2;
        if (uart_valid !== 1'b0) begin miscompares++; $display("FAIL lat_c1_valid: got %b, required 0", uart_valid); end
        if (busy !== 1'b1)       begin miscompares++; $display("FAIL lat_c1_busy: got %b, required 1", busy); end
        @(negedge clk);
        vectors++;
        if (uart_valid !== 1'b1) begin miscompares++; $display("FAIL lat_c2_valid: got %b, required 1", uart_valid); end
        wait_accept(0, 1'b1);
        drop(0);
    endtask

    task automatic test_back_to_back();
        push_byte(2'd0, 8'h21, 1'b1);
        push_byte(2'd0, 8'h22, 1'b1);
        set_req(0, 8'h21, 1'b1);
        wait_accept(0, 1'b0);
        set_req(0, 8'h22, 1'b1);
        @(negedge clk);
        vectors += 2;
        if (busy !== 1'b0)       begin miscompares++; $display("FAIL b2b_idle_busy: got %b, required 0", busy); end
        if (uart_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_valid: got %b, required 0", uart_valid); end
        @(negedge clk);
        vectors += 2;
        if (busy !== 1'b1)       begin miscompares++; $display("FAIL b2b_grant_busy: got %b, required 1", busy); end
        if (uart_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_grant_valid: got %b, required 0", uart_valid); end
        @(negedge clk);
        vectors++;
        if (uart_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_send_valid: got %b, required 1", uart_valid); end
        wait_accept(0, 1'b1);
        drop(0);
    endtask

    task automatic test_gap();
        push_byte(2'd1, 8'h55, 1'b1);
        push_byte(2'd1, 8'hAA, 1'b0);
        push_byte(2'd3, 8'h33, 1'b1);
        set_req(1, 8'h55, 1'b0);
        wait_accept(1, 1'b0);
        drop(1);
        set_req(3, 8'h33, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors += 3;
            if (grant_id !== 2'd1)   begin miscompares++; $display("FAIL gap_grant c%0d: got %0d, required 1", c, grant_id); end
            if (uart_valid !== 1'b0) begin miscompares++; $display("FAIL gap_valid c%0d: got %b, required 0", c, uart_valid); end
            if (req_ready[3] !== 1'b0) begin miscompares++; $display("FAIL gap_ready3 c%0d: got %b, required 0", c, req_ready[3]); end
            @(posedge clk);
            #1;
        end
        set_req(1, 8'hAA, 1'b1);
        wait_accept(1, 1'b0);
        drop(1);
        wait_accept(3, 1'b0);
        drop(3);
    endtask

    task automatic test_stall();
        bit found = 1'b0;
        push_byte(2'd2, 8'h5A, 1'b1);
        uart_ready = 1'b0;
        set_req(2, 8'h5A, 1'b1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (uart_valid && uart_data == 8'h5A) begin
                found = 1'b1;
                break;
            end else if (uart_valid) begin
                @(posedge clk); #1; uart_ready = 1'b1;
                @(posedge clk); #1; uart_ready = 1'b0;
            end
        end
        vectors++;
        if (!found) begin miscompares++; $display("FAIL stall_start: uart_data=%h, required 5a offered", uart_data); end
        @(posedge clk);
        #1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            vectors += 3;
            if (uart_data !== 8'h5A) begin miscompares++; $display("FAIL stall_data c%0d: got %h, required 5a", c, uart_data); end
            if (uart_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid c%0d: got %b, required 1", c, uart_valid); end
            if (req_ready !== 4'b0)  begin miscompares++; $display("FAIL stall_ready c%0d: got %b, required 0000", c, req_ready); end
            @(posedge clk);
            #1;
        end
        uart_ready = 1'b1;
        wait_accept(2, 1'b0);
        drop(2);
    endtask

    // Pointer is 3 going in; after reset requester 1 must win over 3.
    task automatic test_mid_reset();
        push_byte(2'd1, 8'h77, 1'b1);
        set_req(1, 8'h77, 1'b0);
        wait_accept(1, 1'b0);
        uart_ready = 1'b0;
        set_req(1, 8'h78, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors += 6;
        if (uart_valid !== 1'b0) begin miscompares++; $display("FAIL mrst_valid: got %b, required 0", uart_valid); end
        if (req_ready !== 4'b0)  begin miscompares++; $display("FAIL mrst_ready: got %b, required 0000", req_ready); end
        if (uart_data !== 8'h00) begin miscompares++; $display("FAIL mrst_data: got %h, required 00", uart_data); end
        if (busy !== 1'b0)       begin miscompares++; $display("FAIL mrst_busy: got %b, required 0", busy); end
        if (grant_id !== 2'd0)   begin miscompares++; $display("FAIL mrst_grant: got %0d, required 0", grant_id); end
        if (sb.size() != 0)      begin miscompares++; $display("FAIL mrst_pending: %0d bytes outstanding, required 0", sb.size()); end
        @(posedge clk);
        #1;
        drop(1);
        uart_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_byte(2'd1, 8'h61, 1'b1);
        push_byte(2'd3, 8'h63, 1'b1);
        set_req(1, 8'h61, 1'b1);
        set_req(3, 8'h63, 1'b1);
        wait_accept(1, 1'b0);
        drop(1);
        wait_accept(3, 1'b0);
        drop(3);
    endtask

    task automatic test_id_byte();
        push_byte(2'd3, 8'h41, 1'b1);
        set_req(3, 8'h41, 1'b1);
        wait_accept(3, 1'b0);
        drop(3);
    endtask

    initial begin
        test_reset();
        test_two_packets();
        test_rotation();
        test_latency();
        test_back_to_back();
        test_gap();
        test_stall();
        test_mid_reset();
        test_id_byte();
        repeat (4) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: %0d expected bytes never seen, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
